// File: rtl/vga_pll_sup_pkg.sv
// Shared encodings and widths for the VGA pixel-clock PLL supervisor.
// State values are visible on the debug port, so they stay fixed.
package vga_pll_sup_pkg;

    localparam int STATE_W = 3;
    localparam int LOSS_W  = 8;

    localparam logic [LOSS_W-1:0] LOSS_MAX = 8'hFF;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD   = 3'd0,
        S_WAIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer for a level signal,
// asynchronously cleared to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/vga_pll_supervisor.sv
// Pixel PLL bring-up supervisor on refclk: sequences pll_rst,
// qualifies lock and gates the pixel-domain reset.
module vga_pll_supervisor
    import vga_pll_sup_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int MAX_RETRIES     = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic                dom_rst,
    output logic                ready,
    output logic                fault,
    output logic [STATE_W-1:0]  state,
    output logic [1:0]          retry_cnt,
    output logic [LOSS_W-1:0]   lock_loss_cnt
);

    logic              locked_s;
    state_t            cur;
    state_t            nxt;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  timer_nxt;
    logic [1:0]        retry_nxt;
    logic [LOSS_W-1:0] loss_nxt;
    logic              hold_done;
    logic              lock_to;
    logic              settle_done;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign hold_done   = timer == CNT_W'(RST_HOLD_CYCLES - 1);
    assign lock_to     = timer == CNT_W'(LOCK_TIMEOUT - 1);
    assign settle_done = timer == CNT_W'(SETTLE_CYCLES - 1);

    always_comb begin
        nxt       = cur;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;

        case (cur)
            S_HOLD: begin
                if (hold_done) begin
                    nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (locked_s) begin
                    nxt = S_SETTLE;
                end else if (lock_to) begin
                    if (retry_cnt == 2'(MAX_RETRIES)) begin
                        nxt = S_FAULT;
                    end else begin
                        retry_nxt = retry_cnt + 2'd1;
                        nxt       = S_HOLD;
                    end
                end
            end
            S_SETTLE: begin
                if (!locked_s) begin
                    nxt = S_WAIT;
                end else if (settle_done) begin
                    nxt       = S_RUN;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                // lock loss is counted even when a relock request overrides
                if (!locked_s) begin
                    nxt = S_HOLD;
                    if (lock_loss_cnt != LOSS_MAX) begin
                        loss_nxt = lock_loss_cnt + LOSS_W'(1);
                    end
                end
            end
            S_FAULT: begin
                nxt = S_FAULT;
            end
            default: begin
                nxt = S_HOLD;
            end
        endcase

        if (relock_req) begin
            nxt       = S_HOLD;
            retry_nxt = '0;
        end

        if (nxt != cur || relock_req) begin
            timer_nxt = '0;
        end else begin
            timer_nxt = timer + CNT_W'(1);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur           <= S_HOLD;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            dom_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            cur           <= nxt;
            timer         <= timer_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= (nxt == S_HOLD) || (nxt == S_FAULT);
            dom_rst       <= nxt != S_RUN;
            ready         <= nxt == S_RUN;
            fault         <= nxt == S_FAULT;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_vga_pll_supervisor.sv
// Self-checking bench for vga_pll_supervisor: timing tables,
// directed corner sequences and random lock traffic vs a model.
module tb_vga_pll_supervisor;

    localparam int HOLD_N   = 4;
    localparam int TMO      = 20;
    localparam int SETTLE_N = 8;
    localparam int RETRIES  = 2;
    localparam int SYNC     = 2;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       dom_rst;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int n = 0;

    always #10 refclk = ~refclk;

    vga_pll_supervisor #(
        .RST_HOLD_CYCLES (HOLD_N),
        .LOCK_TIMEOUT    (TMO),
        .SETTLE_CYCLES   (SETTLE_N),
        .MAX_RETRIES     (RETRIES),
        .SYNC_STAGES     (SYNC),
        .CNT_W           (16)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .dom_rst       (dom_rst),
        .ready         (ready),
        .fault         (fault),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d",
                     name, n, act, exp);
        end
    endtask

    // Reference model: phase and dwell time per the rules, lock seen
    // through a delay queue of SYNC samples.
    int m_ph;
    int m_dwell;
    int m_retry;
    int m_loss;
    bit lk_hist[$];

    task automatic model_step(bit lk, bit rq);
        bit ls;
        int np;
        ls = lk_hist.pop_front();
        lk_hist.push_back(lk);
        np = m_ph;
        if (m_ph == P_RUN && !ls)
            m_loss = (m_loss >= 255) ? 255 : m_loss + 1;
        if (rq) begin
            np = P_HOLD;
            m_retry = 0;
        end else if (m_ph == P_HOLD) begin
            if (m_dwell + 1 >= HOLD_N) np = P_WAIT;
        end else if (m_ph == P_WAIT) begin
            if (ls) np = P_SETTLE;
            else if (m_dwell + 1 >= TMO) begin
                if (m_retry >= RETRIES) np = P_FAULT;
                else begin
                    m_retry = m_retry + 1;
                    np = P_HOLD;
                end
            end
        end else if (m_ph == P_SETTLE) begin
            if (!ls) np = P_WAIT;
            else if (m_dwell + 1 >= SETTLE_N) begin
                np = P_RUN;
                m_retry = 0;
            end
        end else if (m_ph == P_RUN) begin
            if (!ls) np = P_HOLD;
        end
        m_dwell = (np != m_ph || rq) ? 0 : m_dwell + 1;
        m_ph = np;
    endtask

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_ph = P_HOLD;
            m_dwell = 0;
            m_retry = 0;
            m_loss = 0;
            lk_hist.delete();
            for (int i = 0; i < SYNC; i++) lk_hist.push_back(1'b0);
        end else begin
            model_step(pll_locked, relock_req);
        end
    end

    always @(negedge refclk) begin
        if (!rst) begin
            check("m_state", 32'(state), 32'(m_ph));
            check("m_pll_rst", 32'(pll_rst),
                  32'(m_ph == P_HOLD || m_ph == P_FAULT));
            check("m_dom_rst", 32'(dom_rst), 32'(m_ph != P_RUN));
            check("m_ready", 32'(ready), 32'(m_ph == P_RUN));
            check("m_fault", 32'(fault), 32'(m_ph == P_FAULT));
            check("m_retry", 32'(retry_cnt), 32'(m_retry));
            check("m_loss", 32'(lock_loss_cnt), 32'(m_loss));
        end
    end

    task automatic tick();
        @(posedge refclk);
        n++;
        #1;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_pll_rst"}, 32'(pll_rst), 1);
        check({tag, "_dom_rst"}, 32'(dom_rst), 1);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_fault"}, 32'(fault), 0);
        check({tag, "_retry"}, 32'(retry_cnt), 0);
        check({tag, "_loss"}, 32'(lock_loss_cnt), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(posedge refclk);
        #3;
        rst = 1'b0;
        n = 0;
        check_reset_vals("rst");
    endtask

    task automatic wait_ready(int budget);
        int k = 0;
        while (!ready && k < budget) begin
            tick();
            k++;
        end
        check("wait_ready", 32'(ready), 1);
    endtask

    task automatic wait_hold(int budget);
        int k = 0;
        while (state != 3'd0 && k < budget) begin
            tick();
            k++;
        end
        check("wait_hold", 32'(state), 0);
    endtask

    typedef struct {
        int d;
        int ready_edge;
        int retry_max;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int maxr;
        int hi;
        int fc;

        // lock delay after pll_rst falls -> edge where ready rises
        vecs[0] = '{0, 15, 0};
        vecs[1] = '{5, 20, 0};
        vecs[2] = '{17, 32, 0};
        vecs[3] = '{18, 37, 1};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            maxr = 0;
            for (int c = 1; c <= vecs[v].ready_edge + 1; c++) begin
                tick();
                if (int'(retry_cnt) > maxr) maxr = int'(retry_cnt);
                if (c == HOLD_N - 1) check("bu_pll_rst_hi", 32'(pll_rst), 1);
                if (c == HOLD_N) check("bu_pll_rst_lo", 32'(pll_rst), 0);
                if (c == vecs[v].ready_edge - 1)
                    check("bu_ready_early", 32'(ready), 0);
                if (c == vecs[v].ready_edge) begin
                    check("bu_ready", 32'(ready), 1);
                    check("bu_dom_rst", 32'(dom_rst), 0);
                    check("bu_retry", 32'(retry_cnt), 0);
                end
                if (c == HOLD_N + vecs[v].d) pll_locked = 1'b1;
            end
            check("bu_retry_max", 32'(maxr), 32'(vecs[v].retry_max));
        end

        // lock never asserts
        do_reset();
        hi = 1;
        for (int c = 1; c <= 72; c++) begin
            tick();
            if (c < 72 && pll_rst) hi++;
            if (c == 71) check("tmo_fault_early", 32'(fault), 0);
        end
        check("tmo_pll_rst_cycles", 32'(hi), 12);
        check("tmo_fault", 32'(fault), 1);
        check("tmo_state", 32'(state), 4);
        check("tmo_retry", 32'(retry_cnt), 2);
        check("tmo_pll_rst", 32'(pll_rst), 1);
        fc = 0;
        repeat (200) begin
            tick();
            if (fault && pll_rst) fc++;
        end
        check("fault_hold", 32'(fc), 200);

        // relock out of FAULT, then relock from RUN
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("rq_fault_state", 32'(state), 0);
        check("rq_fault_fault", 32'(fault), 0);
        check("rq_fault_retry", 32'(retry_cnt), 0);
        pll_locked = 1'b1;
        wait_ready(100);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("rq_run_state", 32'(state), 0);
        check("rq_run_loss", 32'(lock_loss_cnt), 0);
        wait_ready(100);

        // single-cycle lock glitch in SETTLE, then lock loss in RUN
        do_reset();
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (c == 13) check("gl_settle", 32'(state), 2);
            if (c == 14) check("gl_wait", 32'(state), 1);
            if (c == 15) check("gl_resettle", 32'(state), 2);
            if (c == 22) check("gl_ready_early", 32'(ready), 0);
            if (c == 23) check("gl_ready", 32'(ready), 1);
            if (c == 26) check("ll_dom_rst_lo", 32'(dom_rst), 0);
            if (c == 27) begin
                check("ll_dom_rst_hi", 32'(dom_rst), 1);
                check("ll_pll_rst_on", 32'(pll_rst), 1);
            end
            if (c == 30) check("ll_pll_rst_on4", 32'(pll_rst), 1);
            if (c == 31) begin
                check("ll_pll_rst_off", 32'(pll_rst), 0);
                check("ll_loss1", 32'(lock_loss_cnt), 1);
            end
            if (c == HOLD_N) pll_locked = 1'b1;
            if (c == 11) pll_locked = 1'b0;
            if (c == 12) pll_locked = 1'b1;
            if (c == 24) pll_locked = 1'b0;
        end
        check("gl_loss0_gone", 32'(lock_loss_cnt), 1);

        // saturate the loss counter
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b1;
            wait_ready(60);
            pll_locked = 1'b0;
            wait_hold(10);
        end
        check("loss_sat", 32'(lock_loss_cnt), 255);

        // async reset between edges mid-SETTLE
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == HOLD_N) pll_locked = 1'b1;
        end
        check("ar_in_settle", 32'(state), 2);
        #5;
        rst = 1'b1;
        #1;
        check_reset_vals("async");
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == HOLD_N) pll_locked = 1'b1;
        end
        check("ar_rebringup", 32'(ready), 1);

        // random lock traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            relock_req = ($urandom_range(0, 249) == 0);
        end
        relock_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
